// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN convolution read path.
// Contents:
//   DATA_W, K, KK, IMG_AW, WGT_AW  - datapath and RAM geometry
//   DIM_W, TAP_W, ADDR_CALC_W      - widths of image dimensions, tap counters
//                                    and the intermediate image address
//   state_t                        - read sequencer states
package cnn_pkg;

    localparam int DATA_W      = 128;
    localparam int K           = 5;
    localparam int KK          = K * K;
    localparam int IMG_AW      = 10;
    localparam int WGT_AW      = 5;
    localparam int DIM_W       = 6;
    localparam int TAP_W       = 3;
    localparam int ADDR_CALC_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/conv_window_counter.sv
// Nested window counters for the convolution sweep.
// kx steps fastest, then ky, then the window origin ox, then oy.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   step            advance the counters by one tap
//   clear           force all counters to 0 (takes priority over step)
//   W, H            image width/height, both >= K while stepping
//   kx, ky          tap position inside the kernel
//   ox, oy          window origin
//   lastTap         current tap is the final tap of a window
//   lastAddr        current tap is the final tap of the final window
module conv_window_counter
    import cnn_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    input  logic               clear,
    input  logic [DIM_W-1:0]   W,
    input  logic [DIM_W-1:0]   H,
    output logic [TAP_W-1:0]   kx,
    output logic [TAP_W-1:0]   ky,
    output logic [DIM_W-1:0]   ox,
    output logic [DIM_W-1:0]   oy,
    output logic               lastTap,
    output logic               lastAddr
);

    localparam logic [TAP_W-1:0] KMAX = TAP_W'(K - 1);

    logic [DIM_W-1:0] oxMax;
    logic [DIM_W-1:0] oyMax;

    // Last valid window origin; only meaningful when W, H >= K.
    assign oxMax = W - DIM_W'(K - 1) - DIM_W'(1);
    assign oyMax = H - DIM_W'(K - 1) - DIM_W'(1);

    assign lastTap  = (kx == KMAX) && (ky == KMAX);
    assign lastAddr = lastTap && (ox == oxMax) && (oy == oyMax);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kx <= '0;
            ky <= '0;
            ox <= '0;
            oy <= '0;
        end else if (clear) begin
            kx <= '0;
            ky <= '0;
            ox <= '0;
            oy <= '0;
        end else if (step) begin
            if (kx == KMAX) begin
                kx <= '0;
                if (ky == KMAX) begin
                    ky <= '0;
                    if (ox == oxMax) begin
                        ox <= '0;
                        oy <= (oy == oyMax) ? '0 : oy + DIM_W'(1);
                    end else begin
                        ox <= ox + DIM_W'(1);
                    end
                end else begin
                    ky <= ky + TAP_W'(1);
                end
            end else begin
                kx <= kx + TAP_W'(1);
            end
        end
    end

endmodule

// File: rtl/ram_read.sv
// Read-side sequencer for the CNN image and weight RAMs.
// Sweeps every valid KxK window of a W x H image, reading image pixels and
// kernel weights in lockstep and streaming the pairs over valid/ready.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   convStart                      level: both RAMs loaded, start/keep sweep
//   W, H                           image dimensions
//   ramImage_en/_addrR/_dout       image RAM read port (1-cycle latency)
//   ramWeight_en/_addrR/_dout      weight RAM read port (1-cycle latency)
//   out_valid/out_ready            output handshake
//   out_pixel/out_weight           RAM data pass-through
//   out_first/out_last             beat is tap 0 / final tap of a window
//   convFinish                     level: sweep complete
module ram_read
    import cnn_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                convStart,
    input  logic [DIM_W-1:0]    W,
    input  logic [DIM_W-1:0]    H,
    output logic                ramImage_en,
    output logic [IMG_AW-1:0]   ramImage_addrR,
    input  logic [DATA_W-1:0]   ramImage_dout,
    output logic                ramWeight_en,
    output logic [WGT_AW-1:0]   ramWeight_addrR,
    input  logic [DATA_W-1:0]   ramWeight_dout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_pixel,
    output logic [DATA_W-1:0]   out_weight,
    output logic                out_first,
    output logic                out_last,
    output logic                convFinish
);

    state_t state;
    state_t nextState;

    logic                   startD;
    logic                   startRise;
    logic                   dimsOk;
    logic                   advance;
    logic                   issue;
    logic                   abort;
    logic [TAP_W-1:0]       kx;
    logic [TAP_W-1:0]       ky;
    logic [DIM_W-1:0]       ox;
    logic [DIM_W-1:0]       oy;
    logic                   lastTap;
    logic                   lastAddr;
    logic                   firstTap;
    logic [ADDR_CALC_W-1:0] rowIdx;
    logic [ADDR_CALC_W-1:0] colIdx;
    logic [ADDR_CALC_W-1:0] addrFull;

    assign startRise = convStart && !startD;
    assign dimsOk    = (W >= DIM_W'(K)) && (H >= DIM_W'(K));

    // A new address may be issued whenever the output slot is empty or is
    // being drained this cycle; otherwise the RAMs hold their outputs.
    assign advance = !out_valid || out_ready;
    assign issue   = (state == RUN) && advance;
    assign abort   = ((state == RUN) || (state == DRAIN)) && !convStart;

    assign ramImage_en  = issue;
    assign ramWeight_en = issue;

    conv_window_counter u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (issue),
        .clear    (state != RUN),
        .W        (W),
        .H        (H),
        .kx       (kx),
        .ky       (ky),
        .ox       (ox),
        .oy       (oy),
        .lastTap  (lastTap),
        .lastAddr (lastAddr)
    );

    assign firstTap = (kx == '0) && (ky == '0);

    // Image address is formed at 12 bits and truncated to the RAM width.
    assign rowIdx          = ADDR_CALC_W'(oy) + ADDR_CALC_W'(ky);
    assign colIdx          = ADDR_CALC_W'(ox) + ADDR_CALC_W'(kx);
    assign addrFull        = rowIdx * ADDR_CALC_W'(W) + colIdx;
    assign ramImage_addrR  = IMG_AW'(addrFull);
    assign ramWeight_addrR = WGT_AW'(ky) * WGT_AW'(K) + WGT_AW'(kx);

    assign out_pixel  = ramImage_dout;
    assign out_weight = ramWeight_dout;
    assign convFinish = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            startD <= 1'b0;
        end else begin
            state  <= nextState;
            startD <= convStart;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (startRise) begin
                    nextState = dimsOk ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    nextState = IDLE;
                end else if (issue && lastAddr) begin
                    nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    nextState = IDLE;
                end else if (out_valid && out_ready) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                if (!convStart) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Flags travel with the read: they describe the address issued in the
    // cycle before the RAM data appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (abort) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (advance) begin
            out_valid <= issue;
            out_first <= issue && firstTap;
            out_last  <= issue && lastTap;
        end
    end

endmodule

// File: tb/tb_ram_read.sv
module tb_ram_read;

    typedef logic [259:0] wide_t;

    logic         clk;
    logic         rst_n;
    logic         convStart;
    logic [5:0]   W;
    logic [5:0]   H;
    logic         ramImage_en;
    logic [9:0]   ramImage_addrR;
    logic [127:0] ramImage_dout;
    logic         ramWeight_en;
    logic [4:0]   ramWeight_addrR;
    logic [127:0] ramWeight_dout;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_pixel;
    logic [127:0] out_weight;
    logic         out_first;
    logic         out_last;
    logic         convFinish;

    logic [127:0] imgMem [1024];
    logic [127:0] wgtMem [32];

    int checks;
    int errors;

    ram_read dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .convStart       (convStart),
        .W               (W),
        .H               (H),
        .ramImage_en     (ramImage_en),
        .ramImage_addrR  (ramImage_addrR),
        .ramImage_dout   (ramImage_dout),
        .ramWeight_en    (ramWeight_en),
        .ramWeight_addrR (ramWeight_addrR),
        .ramWeight_dout  (ramWeight_dout),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pixel       (out_pixel),
        .out_weight      (out_weight),
        .out_first       (out_first),
        .out_last        (out_last),
        .convFinish      (convFinish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM models: 1-cycle latency, output holds while en=0.
    initial begin
        ramImage_dout  = '0;
        ramWeight_dout = '0;
    end
    always @(posedge clk) begin
        if (ramImage_en)  ramImage_dout  <= imgMem[ramImage_addrR];
        if (ramWeight_en) ramWeight_dout <= wgtMem[ramWeight_addrR];
    end

    task automatic check(input string tag, input wide_t obs, input wide_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fillAddr();
        for (int a = 0; a < 1024; a++) imgMem[a] = 128'(a);
        for (int a = 0; a < 32; a++)   wgtMem[a] = 128'(a);
    endtask

    task automatic fillRandom();
        for (int a = 0; a < 1024; a++) imgMem[a] = {$urandom, $urandom, $urandom, $urandom};
        for (int a = 0; a < 32; a++)   wgtMem[a] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    function automatic logic pickReady(input int pct);
        return (pct >= 100) ? 1'b1 : (int'($urandom_range(99)) < pct);
    endfunction

    // Runs one sweep and compares every accepted beat with a reference list
    // built straight from the window definition. abortAt >= 0 drops
    // convStart once that many beats have been accepted.
    task automatic sweep(input int w, input int h, input int pct, input int abortAt);
        logic [127:0] expP[$];
        logic [127:0] expW[$];
        logic [1:0]   expF[$];
        int           n;
        int           cyc;
        int           accepted;
        int           firstValid;
        bit           finished;
        logic         prevHold;
        wide_t        prevOut;

        for (int oy = 0; oy <= h - 5; oy++)
            for (int ox = 0; ox <= w - 5; ox++)
                for (int ky = 0; ky < 5; ky++)
                    for (int kx = 0; kx < 5; kx++) begin
                        expP.push_back(imgMem[((oy + ky) * w + ox + kx) % 1024]);
                        expW.push_back(wgtMem[ky * 5 + kx]);
                        expF.push_back({(ky == 0 && kx == 0), (ky == 4 && kx == 4)});
                    end
        n = expP.size();

        W = 6'(w);
        H = 6'(h);
        @(negedge clk);
        convStart  = 1'b1;
        out_ready  = pickReady(pct);
        cyc        = 0;
        accepted   = 0;
        firstValid = -1;
        finished   = 0;
        prevHold   = 0;
        prevOut    = '0;

        while (!finished && cyc < n * 8 + 50) begin
            @(negedge clk);
            cyc++;
            check("finish_early", convFinish, 0);
            if (cyc == 1) begin
                check("start_en", {ramImage_en, ramWeight_en}, 2'b11);
                check("start_addr", {ramImage_addrR, ramWeight_addrR}, 0);
                check("start_valid", out_valid, 0);
            end
            if (prevHold)
                check("hold_stable", {out_valid, out_pixel, out_weight, out_first, out_last}, prevOut);
            if (out_valid) begin
                if (firstValid < 0) begin
                    firstValid = cyc;
                    check("first_latency", firstValid, 2);
                end
                if (expP.size() == 0) begin
                    check("extra_beat", expP.size(), 1);
                end else begin
                    check("pixel", out_pixel, expP[0]);
                    check("weight", out_weight, expW[0]);
                    check("flags", {out_first, out_last}, expF[0]);
                end
            end
            if (abortAt >= 0 && accepted == abortAt) begin
                convStart = 1'b0;
                out_ready = 1'b0;
                @(negedge clk);
                check("abort_valid", out_valid, 0);
                repeat (10) begin
                    @(negedge clk);
                    check("abort_quiet", {out_valid, convFinish, ramImage_en}, 0);
                end
                return;
            end
            out_ready = pickReady(pct);
            prevHold  = out_valid && !out_ready;
            prevOut   = {out_valid, out_pixel, out_weight, out_first, out_last};
            if (out_valid && out_ready && expP.size() > 0) begin
                void'(expP.pop_front());
                void'(expW.pop_front());
                void'(expF.pop_front());
                accepted++;
                if (accepted == n) begin
                    @(negedge clk);
                    check("finish_after_last", {convFinish, out_valid}, 2'b10);
                    finished = 1;
                end
            end
        end
        check("sweep_finished", finished, 1);
        check("beat_count", accepted, n);

        repeat (2) begin
            @(negedge clk);
            check("finish_held", convFinish, 1);
        end
        convStart = 1'b0;
        @(negedge clk);
        check("finish_clear", convFinish, 0);
        out_ready = 1'b1;
    endtask

    initial begin
        int cyc;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        convStart = 1'b0;
        W         = '0;
        H         = '0;
        out_ready = 1'b0;
        fillAddr();

        #1;
        check("reset_ctrl", {ramImage_en, ramWeight_en, out_valid, out_first, out_last, convFinish}, 0);
        check("reset_addr", {ramImage_addrR, ramWeight_addrR}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_quiet", {ramImage_en, out_valid, convFinish}, 0);

        // Full 32x32 sweep, memories hold their own addresses.
        out_ready = 1'b1;
        sweep(32, 32, 100, -1);
        check("model_beat24_pixel", imgMem[(0 + 4) * 32 + 4], 132);

        // Smallest image: a single window.
        sweep(5, 5, 100, -1);

        // Back-pressure with random data.
        fillRandom();
        sweep(8, 8, 30, -1);

        // Image too narrow: no beats, finish straight away.
        W = 6'd4;
        H = 6'd32;
        @(negedge clk);
        convStart = 1'b1;
        @(negedge clk);
        check("narrow_no_valid", out_valid, 0);
        @(negedge clk);
        check("narrow_finish", {convFinish, out_valid}, 2'b10);
        convStart = 1'b0;
        @(negedge clk);
        check("narrow_clear", convFinish, 0);

        // Abort at beat 100, then restart from beat 0.
        sweep(8, 8, 100, 100);
        sweep(8, 8, 100, -1);

        // Async reset while waiting for the final beat to be accepted.
        fillAddr();
        W = 6'd5;
        H = 6'd5;
        out_ready = 1'b1;
        @(negedge clk);
        convStart = 1'b1;
        cyc = 0;
        while (!(out_valid && out_last) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_reached", {out_valid, out_last}, 2'b11);
        out_ready = 1'b0;
        @(negedge clk);
        check("drain_hold", {out_valid, out_last, convFinish}, 3'b110);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_ctrl", {ramImage_en, ramWeight_en, out_valid, out_first, out_last, convFinish}, 0);
        check("async_addr", {ramImage_addrR, ramWeight_addrR}, 0);
        convStart = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_idle", {ramImage_en, out_valid, convFinish}, 0);
        end
        out_ready = 1'b1;
        sweep(5, 5, 100, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
